vicuna_core_ctrl: RTL and testbench
===================================

// Module: vicuna_core_ctrl
// PURPOSE
// TL-UL device on xbar_main that owns the run/reset state of the Vicuna worker cores.
// The management core writes CTRL to start or stop each core. Each started core is held
// in reset for ResetHoldCycles, then released. Per-core done flags and run-cycle counters
// are exposed for polling. Outputs drive the reset inputs of the rv_core_vicuna instances.
// PARAMETERS
// NumCores         2  number of controlled Vicuna cores (1..16)
// ResetHoldCycles  4  cycles core_rst_o stays high after start (>=1)
// AutoHalt         1  1: a core_done_i pulse in RUN clears that core's run bit and halts it
// PORTS
// clk_i        in   1          system clock
// rst_i        in   1          synchronous, active-high reset
// tl_i         in   tl_h2d_t   TL-UL request from xbar (device side)
// tl_o         out  tl_d2h_t   TL-UL response to xbar
// core_rst_o   out  NumCores   per-core reset, active-high (top level inverts to rst_ni)
// core_done_i  in   NumCores   per-core completion pulse/level from core software
// BEHAVIOUR
// Reset: tl_o.d_valid=0, a_ready=1, core_rst_o='1, CTRL=0, done=0, all CYCLES=0, FSMs HALT.
// TL-UL: one outstanding request. a_ready = ~d_valid. Accept on a_valid&a_ready.
//  - d_valid rises the cycle after accept and holds, payload stable, until d_ready.
//  - d_source/d_size echo the request. d_opcode: AccessAckData for Get, AccessAck for Put*.
//  - d_error=1 for an unmapped offset, unsupported opcode, or a_size!=2. Writes then have
//    no effect and reads return 0.
//  - Put honours a_mask per byte. PutFullData and PutPartialData are treated alike.
// Register map (byte offset, word aligned; addr[11:0] decoded):
//  0x00 CTRL      RW  [NumCores-1:0] run bits
//  0x04 STATUS    RO  [NumCores-1:0] running (FSM==RUN); [16+NumCores-1:16] done sticky
//  0x08 DONE_CLR  WO  write 1 clears done bit i; reads 0
//  0x10+4*i CYCLES[i]  RO  32-bit count of cycles spent in RUN; wraps 0xFFFFFFFF->0
// Per-core FSM (registered; outputs are Moore):
//  HALT : core_rst_o[i]=1. run[i]=1 -> START, load hold=ResetHoldCycles-1.
//  START: core_rst_o[i]=1. Clear CYCLES[i] and done[i]. hold==0 -> RUN, else hold--.
//         run[i]=0 -> HALT.
//  RUN  : core_rst_o[i]=0, CYCLES[i]++ each cycle. run[i]=0 -> HALT.
//         core_done_i[i]=1 -> done[i]=1; with AutoHalt also run[i]<=0, HALT next cycle.
// Latency: the CTRL write takes effect the cycle after accept. core_rst_o falls
//  ResetHoldCycles+1 cycles after the write-accept edge.
// Simultaneous events:
//  - CTRL write and AutoHalt clear in the same cycle: the write value wins.
//  - DONE_CLR and a done set in the same cycle: the set wins.
//  - core_done_i outside RUN is ignored.
//  - Writing run=1 to a core in START/RUN does not restart it. A restart requires 0 then 1.
// rst_i mid-transaction drops any pending response (d_valid=0 next cycle) and
//  re-asserts all core_rst_o immediately at that edge.
// TESTING
// 1 Post-reset: Get 0x04 -> AccessAckData d_data=0, d_error=0; core_rst_o=2'b11.
// 2 Put CTRL=0x1: core_rst_o[0] falls exactly 5 cycles after accept, core 1 stays in
//   reset; 100 cycles later CYCLES[0] reads 100+/-1 cycles of bus latency.
// 3 Pulse core_done_i[0] in RUN, AutoHalt=1: STATUS=0x0001_0000, CTRL=0,
//   core_rst_o[0]=1; then DONE_CLR=0x1 -> STATUS=0.
// 4 Get 0x0C and Put with a_size=1 -> d_error=1, registers unchanged; hold d_ready=0
//   for 3 cycles -> d_valid and payload stable, a_ready=0 throughout.
// 5 Same cycle: DONE_CLR bit0 write and core_done_i[0] -> done[0] reads 1.
// 6 Force CYCLES[0]=0xFFFF_FFFF in RUN -> next cycle reads 0. Assert rst_i mid-RUN ->
//   core_rst_o='1 and all CSRs 0.

Source files
------------

// File: rtl/vicuna_core_ctrl.sv
// Run/reset controller for the Vicuna worker cores, exposed as a TL-UL register device.
// Latency: TL-UL response one cycle after accept; core_rst_o falls ResetHoldCycles+1 cycles after a CTRL write.
// Backpressure: one outstanding request; a_ready is low while a response waits for d_ready.

package vicuna_core_ctrl_pkg;
  localparam logic [2:0] TL_PUT_FULL    = 3'h0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'h1;
  localparam logic [2:0] TL_GET         = 3'h4;
  localparam logic [2:0] TL_ACK         = 3'h0;
  localparam logic [2:0] TL_ACK_DATA    = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module vicuna_core_ctrl
  import vicuna_core_ctrl_pkg::*;
#(
  parameter int unsigned NumCores        = 2,
  parameter int unsigned ResetHoldCycles = 4,
  parameter bit          AutoHalt        = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  tl_h2d_t             tl_i,
  output tl_d2h_t             tl_o,
  output logic [NumCores-1:0] core_rst_o,
  input  logic [NumCores-1:0] core_done_i
);

  localparam int unsigned      HoldW    = (ResetHoldCycles > 1) ? $clog2(ResetHoldCycles) : 1;
  localparam logic [HoldW-1:0] HoldInit = HoldW'(ResetHoldCycles - 1);

  typedef enum logic [1:0] {HALT, START, RUN} core_state_e;

  logic                d_valid_q;
  logic [2:0]          d_opcode_q;
  logic [1:0]          d_size_q;
  logic [7:0]          d_source_q;
  logic [31:0]         d_data_q;
  logic                d_error_q;

  logic                accept, is_get, is_put, size_ok, addr_hit, req_err;
  logic                ctrl_we, clr_we;
  logic [11:0]         offset;
  logic [31:0]         wmask, rdata;
  logic [NumCores-1:0] ctrl_wval, clr_bits;
  logic [NumCores-1:0] run_vec, running_vec, done_vec;
  logic [31:0]         cycles_arr [NumCores];
  logic                unused_bits;

  assign offset  = tl_i.a_address[11:0];
  assign accept  = tl_i.a_valid & ~d_valid_q;
  assign is_get  = (tl_i.a_opcode == TL_GET);
  assign is_put  = (tl_i.a_opcode == TL_PUT_FULL) | (tl_i.a_opcode == TL_PUT_PARTIAL);
  assign size_ok = (tl_i.a_size == 2'd2);
  assign wmask   = {{8{tl_i.a_mask[3]}}, {8{tl_i.a_mask[2]}}, {8{tl_i.a_mask[1]}}, {8{tl_i.a_mask[0]}}};

  // Address decode and read mux; misaligned offsets simply never match
  always_comb begin
    addr_hit = 1'b0;
    rdata    = '0;
    if (offset == 12'h000) begin
      addr_hit              = 1'b1;
      rdata[NumCores-1:0]   = run_vec;
    end else if (offset == 12'h004) begin
      addr_hit              = 1'b1;
      rdata[NumCores-1:0]   = running_vec;
      rdata[16 +: NumCores] = done_vec;
    end else if (offset == 12'h008) begin
      addr_hit              = 1'b1;
    end else begin
      for (int i = 0; i < NumCores; i++) begin
        if (offset == 12'h010 + 12'(4 * i)) begin
          addr_hit = 1'b1;
          rdata    = cycles_arr[i];
        end
      end
    end
  end

  assign req_err   = ~addr_hit | ~(is_get | is_put) | ~size_ok;
  assign ctrl_we   = accept & is_put & ~req_err & (offset == 12'h000);
  assign clr_we    = accept & is_put & ~req_err & (offset == 12'h008);
  assign ctrl_wval = (run_vec & ~wmask[NumCores-1:0]) | (tl_i.a_data[NumCores-1:0] & wmask[NumCores-1:0]);
  assign clr_bits  = tl_i.a_data[NumCores-1:0] & wmask[NumCores-1:0];

  assign unused_bits = ^{tl_i.a_param, tl_i.a_address[31:12], tl_i.a_data[31:NumCores], wmask[31:NumCores]};

  // Response channel: capture on accept, hold until d_ready; reset drops a pending response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_valid_q  <= 1'b0;
      d_opcode_q <= TL_ACK;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else if (accept) begin
      d_valid_q  <= 1'b1;
      d_opcode_q <= is_get ? TL_ACK_DATA : TL_ACK;
      d_size_q   <= tl_i.a_size;
      d_source_q <= tl_i.a_source;
      d_data_q   <= (is_get && !req_err) ? rdata : 32'h0;
      d_error_q  <= req_err;
    end else if (tl_i.d_ready) begin
      d_valid_q  <= 1'b0;
    end
  end

  // Drive the response struct from the holding registers
  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid_q;
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_data   = d_data_q;
    tl_o.d_error  = d_error_q;
    tl_o.a_ready  = ~d_valid_q;
  end

  for (genvar i = 0; i < NumCores; i++) begin : g_core
    core_state_e      state_q;
    logic [HoldW-1:0] hold_q;
    logic [31:0]      cycles_q;
    logic             done_q, run_q, rst_q;

    // Per-core run bit, sticky done flag and HALT/START/RUN sequencer with registered reset output
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q  <= HALT;
        hold_q   <= '0;
        cycles_q <= '0;
        done_q   <= 1'b0;
        run_q    <= 1'b0;
        rst_q    <= 1'b1;
      end else begin
        // A CTRL write beats the self-clear from a completion pulse
        if (ctrl_we)                                       run_q <= ctrl_wval[i];
        else if (AutoHalt && state_q == RUN && core_done_i[i]) run_q <= 1'b0;

        // Completion set beats a same-cycle DONE_CLR
        if (state_q == START)                        done_q <= 1'b0;
        else if (state_q == RUN && core_done_i[i])   done_q <= 1'b1;
        else if (clr_we && clr_bits[i])              done_q <= 1'b0;

        case (state_q)
          HALT: begin
            rst_q <= 1'b1;
            if (run_q) begin
              state_q <= START;
              hold_q  <= HoldInit;
            end
          end
          START: begin
            cycles_q <= '0;
            if (!run_q) begin
              state_q <= HALT;
            end else if (hold_q == '0) begin
              state_q <= RUN;
              rst_q   <= 1'b0;
            end else begin
              hold_q  <= hold_q - 1'b1;
            end
          end
          RUN: begin
            cycles_q <= cycles_q + 32'd1;
            if (!run_q) begin
              state_q <= HALT;
              rst_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= HALT;
            rst_q   <= 1'b1;
          end
        endcase
      end
    end

    assign run_vec[i]     = run_q;
    assign running_vec[i] = (state_q == RUN);
    assign done_vec[i]    = done_q;
    assign core_rst_o[i]  = rst_q;
    assign cycles_arr[i]  = cycles_q;
  end

endmodule

// File: tb/tb_vicuna_core_ctrl.sv
// Directed bench for vicuna_core_ctrl: bus access, core start latency, done handling, wrap and reset.
// Latency: drives on the falling edge, samples on the falling edge after each DUT clock edge.
// Backpressure: exercises held responses with d_ready low.

module tb_vicuna_core_ctrl;
  import vicuna_core_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  tl_h2d_t    tl_i;
  tl_d2h_t    tl_o;
  logic [1:0] core_rst;
  logic [1:0] core_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  vicuna_core_ctrl #(
    .NumCores        (2),
    .ResetHoldCycles (4),
    .AutoHalt        (1'b1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tl_i        (tl_i),
    .tl_o        (tl_o),
    .core_rst_o  (core_rst),
    .core_done_i (core_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One full transaction; called on a falling edge, returns on a falling edge after the handshake
  task automatic tl_req(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [1:0] size,
                        output logic [31:0] rdata, output logic err, output logic [2:0] dop);
    int n;
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_address = {20'h0, addr};
    tl_i.a_data    = data;
    tl_i.a_mask    = mask;
    tl_i.a_size    = size;
    tl_i.a_source  = 8'h11;
    tl_i.d_ready   = 1'b1;
    n = 0;
    while (!tl_o.a_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    acc_cyc      = cyc;
    tl_i.a_valid = 1'b0;
    n = 0;
    while (!tl_o.d_valid && n < 20) begin @(negedge clk); n++; end
    chk("d_valid_seen", 32'(tl_o.d_valid), 32'd1);
    rdata = tl_o.d_data;
    err   = tl_o.d_error;
    dop   = tl_o.d_opcode;
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] addr, output logic [31:0] data);
    logic       e;
    logic [2:0] o;
    tl_req(TL_GET, addr, 32'h0, 4'hF, 2'd2, data, e, o);
    chk("rd_err", 32'(e), 32'd0);
    chk("rd_opcode", 32'(o), 32'(TL_ACK_DATA));
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic        e;
    logic [2:0]  o;
    tl_req(TL_PUT_FULL, addr, data, 4'hF, 2'd2, d, e, o);
    chk("wr_err", 32'(e), 32'd0);
    chk("wr_opcode", 32'(o), 32'(TL_ACK));
  endtask

  task automatic wait_fall(output int lat);
    int n = 0;
    while (core_rst[0] && n < 40) begin @(negedge clk); n++; end
    lat = cyc - acc_cyc;
    chk("core0_rst_fall_seen", 32'(core_rst[0]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic [2:0]  o;
    int          lat;

    tl_i      = '0;
    core_done = 2'b00;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 1: reset state
    chk("rst_core_rst", 32'(core_rst), 32'h3);
    chk("rst_d_valid", 32'(tl_o.d_valid), 32'd0);
    chk("rst_a_ready", 32'(tl_o.a_ready), 32'd1);
    rd(12'h004, d);
    chk("rst_status", d, 32'h0);
    rd(12'h010, d);
    chk("rst_cycles0", d, 32'h0);

    // 2: start core 0, measure release latency and run time
    wr(12'h000, 32'h1);
    wait_fall(lat);
    chk("rst_fall_latency", 32'(lat), 32'd5);
    chk("core1_held", 32'(core_rst[1]), 32'd1);
    repeat (100) @(negedge clk);
    rd(12'h010, d);
    chk("cycles0_about_100", 32'(d >= 32'd99 && d <= 32'd101), 32'd1);

    // 3: completion pulse auto-halts core 0
    core_done[0] = 1'b1;
    @(negedge clk);
    core_done[0] = 1'b0;
    repeat (2) @(negedge clk);
    rd(12'h004, d);
    chk("autohalt_status", d, 32'h0001_0000);
    rd(12'h000, d);
    chk("autohalt_ctrl", d, 32'h0);
    chk("autohalt_core_rst", 32'(core_rst), 32'h3);
    wr(12'h008, 32'h1);
    rd(12'h004, d);
    chk("done_clr_status", d, 32'h0);

    // 4: error responses, mask, held response
    tl_req(TL_GET, 12'h00C, 32'h0, 4'hF, 2'd2, d, e, o);
    chk("unmapped_err", 32'(e), 32'd1);
    chk("unmapped_data", d, 32'h0);
    tl_req(TL_PUT_FULL, 12'h000, 32'h3, 4'hF, 2'd1, d, e, o);
    chk("size1_err", 32'(e), 32'd1);
    tl_req(TL_PUT_PARTIAL, 12'h000, 32'h3, 4'h0, 2'd2, d, e, o);
    chk("mask0_err", 32'(e), 32'd0);
    rd(12'h000, d);
    chk("ctrl_unchanged", d, 32'h0);
    chk("no_start_core_rst", 32'(core_rst), 32'h3);

    wr(12'h000, 32'h2);
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = TL_GET;
    tl_i.a_address = 32'h0;
    tl_i.a_size    = 2'd2;
    tl_i.a_mask    = 4'hF;
    tl_i.a_source  = 8'h5A;
    tl_i.d_ready   = 1'b0;
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("hold_d_valid", 32'(tl_o.d_valid), 32'd1);
      chk("hold_a_ready", 32'(tl_o.a_ready), 32'd0);
      chk("hold_d_data", tl_o.d_data, 32'h2);
      chk("hold_d_source", 32'(tl_o.d_source), 32'h5A);
      chk("hold_d_opcode", 32'(tl_o.d_opcode), 32'(TL_ACK_DATA));
      chk("hold_d_size", 32'(tl_o.d_size), 32'd2);
      @(negedge clk);
    end
    tl_i.d_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", 32'(tl_o.d_valid), 32'd0);

    // CTRL write beats a same-cycle auto-halt; run=1 on a running core does not restart it
    wr(12'h000, 32'h1);
    wait_fall(lat);
    repeat (3) @(negedge clk);
    core_done[0] = 1'b1;
    fork
      begin @(negedge clk); core_done[0] = 1'b0; end
    join_none
    wr(12'h000, 32'h1);
    chk("write_wins_core_rst0", 32'(core_rst[0]), 32'd0);
    rd(12'h004, d);
    chk("write_wins_status", d, 32'h0001_0001);
    rd(12'h000, d);
    chk("write_wins_ctrl", d, 32'h1);
    wr(12'h008, 32'h1);
    rd(12'h004, d);
    chk("clr_while_run", d, 32'h0000_0001);

    // 5: done set beats a same-cycle DONE_CLR
    core_done[0] = 1'b1;
    fork
      begin @(negedge clk); core_done[0] = 1'b0; end
    join_none
    wr(12'h008, 32'h1);
    repeat (2) @(negedge clk);
    rd(12'h004, d);
    chk("set_beats_clr", d, 32'h0001_0000);
    rd(12'h000, d);
    chk("set_beats_clr_ctrl", d, 32'h0);

    // 6: counter wrap, then reset while running with a response pending
    wr(12'h000, 32'h1);
    wait_fall(lat);
    repeat (3) @(negedge clk);
    force dut.g_core[0].cycles_q = 32'hFFFF_FFFF;
    #1;
    release dut.g_core[0].cycles_q;
    @(negedge clk);
    chk("cycles_wrap", dut.g_core[0].cycles_q, 32'h0);
    @(negedge clk);
    chk("cycles_after_wrap", dut.g_core[0].cycles_q, 32'h1);

    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = TL_GET;
    tl_i.a_address = 32'h10;
    tl_i.d_ready   = 1'b0;
    @(negedge clk);
    tl_i.a_valid = 1'b0;
    chk("pending_before_rst", 32'(tl_o.d_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drops_d_valid", 32'(tl_o.d_valid), 32'd0);
    chk("rst_core_rst_all", 32'(core_rst), 32'h3);
    chk("rst_a_ready_again", 32'(tl_o.a_ready), 32'd1);
    rst          = 1'b0;
    tl_i.d_ready = 1'b1;
    @(negedge clk);
    rd(12'h000, d);
    chk("post_rst_ctrl", d, 32'h0);
    rd(12'h004, d);
    chk("post_rst_status", d, 32'h0);
    rd(12'h010, d);
    chk("post_rst_cycles0", d, 32'h0);
    rd(12'h014, d);
    chk("post_rst_cycles1", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
